// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, SR bit positions and shared PC vectors
package cp0_pkg;

    localparam logic [4:0] SEL_COUNT   = 5'd9;
    localparam logic [4:0] SEL_COMPARE = 5'd11;
    localparam logic [4:0] SEL_SR      = 5'd12;
    localparam logic [4:0] SEL_CAUSE   = 5'd13;
    localparam logic [4:0] SEL_EPC     = 5'd14;
    localparam logic [4:0] SEL_PRID    = 5'd15;

    localparam int IM_HI = 15;
    localparam int IM_LO = 10;
    localparam int EXL   = 1;
    localparam int IE    = 0;

    localparam logic [31:0] RESET_VECTOR   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_VECTOR = 32'h0000_4180;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with sticky pending flag (present only with CP0_COUNT_EN)
`ifdef CP0_COUNT_EN
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  sel,
    input  logic [31:0] din,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        pend
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        pend_q, pend_d;

    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        pend_d    = pend_q;
        if (we && sel == SEL_COUNT) begin
            count_d = din;
        end
        if (count_q == compare_q && compare_q != 32'd0) begin
            pend_d = 1'b1;
        end
        // Writing Compare is the software acknowledge for the timer interrupt.
        if (we && sel == SEL_COMPARE) begin
            compare_d = din;
            pend_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            pend_q    <= pend_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign pend    = pend_q;

endmodule
`endif

// File: rtl/cp0.sv
// rtl/cp0.sv - Coprocessor-0: SR/Cause/EPC/PRId and interrupt request; CP0_COUNT_EN adds Count/Compare timer
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL = 32'h4D49_5053
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  sel,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [31:0] pc,
    input  logic [5:0]  hw_int,
    input  logic        exl_set,
    input  logic        exl_clr,
    output logic        int_req,
    output logic [31:0] epc
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic [5:0]  ip_q, ip_d;
    logic [31:0] epc_q, epc_d;

    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_pend;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

`ifdef CP0_COUNT_EN
    cp0_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .sel     (sel),
        .din     (din),
        .count   (count),
        .compare (compare),
        .pend    (timer_pend)
    );
`else
    assign count      = '0;
    assign compare    = '0;
    assign timer_pend = 1'b0;
`endif

    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        epc_d = epc_q;
        ip_d  = {hw_int[5] | timer_pend, hw_int[4:0]};
        if (we && sel == SEL_SR) begin
            im_d  = din[IM_HI:IM_LO];
            exl_d = din[EXL];
            ie_d  = din[IE];
        end
        if (we && sel == SEL_EPC) begin
            epc_d = din;
        end
        // Controller strobes only override EXL/EPC; IM and IE keep any same-cycle mtc0.
        if (exl_set) begin
            exl_d = 1'b1;
            epc_d = word_align(pc);
        end else if (exl_clr) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            ip_q  <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            ip_q  <= ip_d;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        sr_val               = '0;
        sr_val[IM_HI:IM_LO]  = im_q;
        sr_val[EXL]          = exl_q;
        sr_val[IE]           = ie_q;
        cause_val            = '0;
        cause_val[IM_HI:IM_LO] = ip_q;
    end

    always_comb begin
        dout = '0;
        case (sel)
            SEL_COUNT:   dout = count;
            SEL_COMPARE: dout = compare;
            SEL_SR:      dout = sr_val;
            SEL_CAUSE:   dout = cause_val;
            SEL_EPC:     dout = epc_q;
            SEL_PRID:    dout = PRID_VAL;
            default:     dout = '0;
        endcase
    end

    assign int_req = (|(ip_q & im_q)) & ie_q & ~exl_q;
    assign epc     = epc_q;

endmodule

// File: tb/tb_cp0.sv
// tb/tb_cp0.sv - self-checking bench for cp0: vector table with scoreboard plus hand sequences
module tb_cp0;

    localparam logic [31:0] PRID = 32'h4D49_5053;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  sel;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] pc;
    logic [5:0]  hw_int;
    logic        exl_set;
    logic        exl_clr;
    logic        int_req;
    logic [31:0] epc;

    cp0 dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .sel     (sel),
        .din     (din),
        .dout    (dout),
        .pc      (pc),
        .hw_int  (hw_int),
        .exl_set (exl_set),
        .exl_clr (exl_clr),
        .int_req (int_req),
        .epc     (epc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  sel;
        logic [31:0] din;
        logic [31:0] pc;
        logic [5:0]  hw;
        logic        es;
        logic        ec;
        logic [4:0]  rsel;
        logic [31:0] x_dout;
        logic        x_irq;
        logic [31:0] x_epc;
    } vec_t;

    typedef struct {
        logic [31:0] dout;
        logic        irq;
        logic [31:0] epc;
    } exp_t;

    vec_t vecs[15];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we = 1'b0; sel = 5'd0; din = '0; pc = '0; exl_set = 1'b0; exl_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        hw_int = '0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] s, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; sel = s; din = d;
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    task automatic mfc0_check(input string name, input logic [4:0] s, input logic [31:0] exp);
        sel = s;
        #1 check(name, dout, exp);
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        we = v.we; sel = v.sel; din = v.din; pc = v.pc;
        hw_int = v.hw; exl_set = v.es; exl_clr = v.ec;
        sb.push_back('{dout: v.x_dout, irq: v.x_irq, epc: v.x_epc});
        @(posedge clk);
        #1;
        we = 1'b0; exl_set = 1'b0; exl_clr = 1'b0; sel = v.rsel;
        #1;
        e = sb.pop_front();
        check($sformatf("vec%0d_dout", idx), dout, e.dout);
        check($sformatf("vec%0d_irq", idx), {31'd0, int_req}, {31'd0, e.irq});
        check($sformatf("vec%0d_epc", idx), epc, e.epc);
    endtask

    initial begin
        logic [31:0] x_count;
        bit          seen;
`ifdef CP0_COUNT_EN
        x_count = 32'hFFFF_FFFF;
`else
        x_count = 32'h0000_0000;
`endif
        //          we  sel    din            pc             hw         es ec rsel   dout           irq epc
        vecs[0]  = '{1, 5'd12, 32'h0000_0401, 32'h0,         6'b000000, 0, 0, 5'd12, 32'h0000_0401, 0, 32'h0};
        vecs[1]  = '{0, 5'd0,  32'h0,         32'h0,         6'b000001, 0, 0, 5'd13, 32'h0000_0400, 1, 32'h0};
        vecs[2]  = '{0, 5'd0,  32'h0,         32'h0000_3017, 6'b000001, 1, 0, 5'd12, 32'h0000_0403, 0, 32'h0000_3014};
        vecs[3]  = '{0, 5'd0,  32'h0,         32'h0,         6'b000001, 0, 0, 5'd14, 32'h0000_3014, 0, 32'h0000_3014};
        vecs[4]  = '{0, 5'd0,  32'h0,         32'h0,         6'b000001, 0, 1, 5'd12, 32'h0000_0401, 1, 32'h0000_3014};
        vecs[5]  = '{0, 5'd0,  32'h0,         32'h0,         6'b000000, 0, 0, 5'd13, 32'h0000_0000, 0, 32'h0000_3014};
        vecs[6]  = '{1, 5'd14, 32'h1234_5678, 32'h0000_3020, 6'b000000, 1, 0, 5'd14, 32'h0000_3020, 0, 32'h0000_3020};
        vecs[7]  = '{0, 5'd0,  32'h0,         32'h0000_3020, 6'b000000, 1, 1, 5'd12, 32'h0000_0403, 0, 32'h0000_3020};
        vecs[8]  = '{1, 5'd12, 32'hFFFF_FFFF, 32'h0,         6'b000000, 0, 1, 5'd12, 32'h0000_FC01, 0, 32'h0000_3020};
        vecs[9]  = '{0, 5'd0,  32'h0,         32'h0,         6'b100000, 0, 0, 5'd13, 32'h0000_8000, 1, 32'h0000_3020};
        vecs[10] = '{1, 5'd13, 32'hFFFF_FFFF, 32'h0,         6'b000000, 0, 0, 5'd13, 32'h0000_0000, 0, 32'h0000_3020};
        vecs[11] = '{1, 5'd15, 32'h0,         32'h0,         6'b000000, 0, 0, 5'd15, PRID,          0, 32'h0000_3020};
        vecs[12] = '{1, 5'd9,  32'hFFFF_FFFF, 32'h0,         6'b000000, 0, 0, 5'd9,  x_count,       0, 32'h0000_3020};
        vecs[13] = '{1, 5'd3,  32'hFFFF_FFFF, 32'h0,         6'b000000, 0, 0, 5'd3,  32'h0000_0000, 0, 32'h0000_3020};
        vecs[14] = '{1, 5'd14, 32'hAAAA_5555, 32'h0,         6'b000010, 0, 0, 5'd14, 32'hAAAA_5555, 1, 32'hAAAA_5555};

        rst = 1'b1;
        hw_int = '0;
        idle_inputs();

        // Reset state.
        do_reset();
        check("rst_irq", {31'd0, int_req}, 32'd0);
        check("rst_epc", epc, 32'd0);
        mfc0_check("rst_sr", 5'd12, 32'd0);
        mfc0_check("rst_cause", 5'd13, 32'd0);
        mfc0_check("rst_epc_rd", 5'd14, 32'd0);
        mfc0_check("rst_prid", 5'd15, PRID);

        // int_req one cycle after hw_int rises, not in the same cycle.
        mtc0(5'd12, 32'h0000_0401);
        @(negedge clk);
        hw_int = 6'b000001;
        #1 check("irq_same_cycle", {31'd0, int_req}, 32'd0);
        @(posedge clk);
        #1 check("irq_next_cycle", {31'd0, int_req}, 32'd1);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            apply(vecs[i], i);
        end
        check("sb_empty", sb.size(), 32'd0);

        // Reset in the middle of a handler clears EXL and EPC at that edge.
        @(negedge clk);
        exl_set = 1'b1; pc = 32'h0000_4181;
        @(posedge clk);
        #1 exl_set = 1'b0;
        check("handler_epc", epc, 32'h0000_4180);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_epc", epc, 32'd0);
        mfc0_check("midrst_sr", 5'd12, 32'd0);
        check("midrst_irq", {31'd0, int_req}, 32'd0);

`ifdef CP0_COUNT_EN
        do_reset();
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        mtc0(5'd12, 32'h0000_8001);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (int_req) seen = 1'b1;
        end
        check("timer_irq", {31'd0, seen}, 32'd1);
        mfc0_check("timer_cause", 5'd13, 32'h0000_8000);
        mtc0(5'd11, 32'd100);
        @(posedge clk);
        #1 check("timer_ack", {31'd0, int_req}, 32'd0);
        mfc0_check("timer_compare", 5'd11, 32'd100);
`else
        seen = 1'b0;
        check("no_timer_seen", {31'd0, seen}, {31'd0, int_req});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
